// File: rtl/opm_window_avg.sv
// ============================================================================
// Module      : opm_window_avg
// Description : Averages the per-cycle opm power estimate over fixed windows
//               of 2**LOG_WIN valid samples. Each result is offered on a
//               one-entry valid/ready port. A hysteretic over-threshold alarm
//               is raised for the power-management controller.
//               Optional feature macro: OPM_WINDOW_PEAK_EN (adds peak_out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opm_window_avg #(
    parameter int IN_W    = 10,
    parameter int LOG_WIN = 8,
    parameter int HYST    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [IN_W-1:0] pwr_in,
    input  logic            pwr_vld,
    input  logic [IN_W-1:0] thr,
    output logic [IN_W-1:0] avg_out,
    output logic            avg_vld,
    input  logic            avg_rdy,
    output logic            ovf,
    output logic            alarm
`ifdef OPM_WINDOW_PEAK_EN
    ,
    output logic [IN_W-1:0] peak_out
`endif
);

    localparam int              c_ACC_W = IN_W + LOG_WIN;
    localparam logic [IN_W-1:0] c_HYST  = IN_W'(HYST);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_ACC_W-1:0]   r_acc;
    logic [LOG_WIN-1:0]   r_cnt;
    logic                 w_take;
    logic                 w_last;
    logic [c_ACC_W-1:0]   w_sum;
    logic [IN_W-1:0]      w_avg;
    logic [IN_W-1:0]      w_thr_lo;

    logic [IN_W-1:0]      r_avg_out;
    logic                 r_avg_vld;
    logic                 r_ovf;
    logic                 r_alarm;

    // Sum including the current sample; the average is its top IN_W bits.
    assign w_sum    = r_acc + {{LOG_WIN{1'b0}}, pwr_in};
    assign w_avg    = w_sum[c_ACC_W-1:LOG_WIN];
    // Alarm clear level, saturating at zero for small thresholds.
    assign w_thr_lo = (thr > c_HYST) ? (thr - c_HYST) : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and per-edge sample qualification; a sample arriving as en
    // drops is discarded together with the partial window.
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_next_state = ST_IDLE;
                end else if (pwr_vld) begin
                    w_take = 1'b1;
                    w_last = (r_cnt == {LOG_WIN{1'b1}});
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Window accumulator and sample counter; cleared outside RUN and at window end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == ST_RUN && en) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_take) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + LOG_WIN'(1);
            end
        end else begin
            r_acc <= '0;
            r_cnt <= '0;
        end
    end

    // Result buffer, overwrite pulse and hysteretic alarm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_avg_out <= '0;
            r_avg_vld <= 1'b0;
            r_ovf     <= 1'b0;
            r_alarm   <= 1'b0;
        end else if (w_last) begin
            r_avg_out <= w_avg;
            r_avg_vld <= 1'b1;
            // Only an unconsumed result that is not accepted this edge is lost.
            r_ovf     <= r_avg_vld & ~avg_rdy;
            if (w_avg >= thr) begin
                r_alarm <= 1'b1;
            end else if (w_avg < w_thr_lo) begin
                r_alarm <= 1'b0;
            end
        end else begin
            r_ovf <= 1'b0;
            if (r_avg_vld && avg_rdy) begin
                r_avg_vld <= 1'b0;
            end
        end
    end

    assign avg_out = r_avg_out;
    assign avg_vld = r_avg_vld;
    assign ovf     = r_ovf;
    assign alarm   = r_alarm;

`ifdef OPM_WINDOW_PEAK_EN
    logic [IN_W-1:0] r_peak;
    logic [IN_W-1:0] r_peak_out;
    logic [IN_W-1:0] w_peak_nx;

    assign w_peak_nx = (pwr_in > r_peak) ? pwr_in : r_peak;

    // Running maximum of the window; published alongside the average.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak     <= '0;
            r_peak_out <= '0;
        end else if (w_last) begin
            r_peak     <= '0;
            r_peak_out <= w_peak_nx;
        end else if (r_state == ST_RUN && en) begin
            if (w_take) begin
                r_peak <= w_peak_nx;
            end
        end else begin
            r_peak <= '0;
        end
    end

    assign peak_out = r_peak_out;
`endif

endmodule

`default_nettype wire

// File: tb/tb_opm_window_avg.sv
// ============================================================================
// Module      : tb_opm_window_avg
// Description : Directed table-driven bench for opm_window_avg with
//               LOG_WIN=2, IN_W=10, HYST=4. Peak checks are active when
//               OPM_WINDOW_PEAK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_opm_window_avg;

    localparam int IN_W    = 10;
    localparam int LOG_WIN = 2;
    localparam int HYST    = 4;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [IN_W-1:0] pwr_in;
    logic            pwr_vld;
    logic [IN_W-1:0] thr;
    logic [IN_W-1:0] avg_out;
    logic            avg_vld;
    logic            avg_rdy;
    logic            ovf;
    logic            alarm;
`ifdef OPM_WINDOW_PEAK_EN
    logic [IN_W-1:0] peak_out;
`endif

    opm_window_avg #(
        .IN_W    (IN_W),
        .LOG_WIN (LOG_WIN),
        .HYST    (HYST)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .pwr_in  (pwr_in),
        .pwr_vld (pwr_vld),
        .thr     (thr),
        .avg_out (avg_out),
        .avg_vld (avg_vld),
        .avg_rdy (avg_rdy),
        .ovf     (ovf),
        .alarm   (alarm)
`ifdef OPM_WINDOW_PEAK_EN
        ,
        .peak_out(peak_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            en;
        logic            vld;
        logic [IN_W-1:0] p;
        logic [IN_W-1:0] thr;
        logic            rdy;
        logic [IN_W-1:0] eavg;
        logic            evld;
        logic            eovf;
        logic            ealm;
        logic [IN_W-1:0] epk;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic e, input logic v, input int p, input int t,
                       input logic r, input int ea, input logic ev,
                       input logic eo, input logic el, input int ep);
        vec_t x;
        x.en   = e;
        x.vld  = v;
        x.p    = IN_W'(p);
        x.thr  = IN_W'(t);
        x.rdy  = r;
        x.eavg = IN_W'(ea);
        x.evld = ev;
        x.eovf = eo;
        x.ealm = el;
        x.epk  = IN_W'(ep);
        vecs.push_back(x);
    endtask

    task automatic chk(input string nm, input int row, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %0d, expected %0d", nm, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input int ea, input logic ev,
                           input logic eo, input logic el, input int ep);
        chk("avg_out", row, int'(avg_out), ea);
        chk("avg_vld", row, int'(avg_vld), int'(ev));
        chk("ovf",     row, int'(ovf),     int'(eo));
        chk("alarm",   row, int'(alarm),   int'(el));
`ifdef OPM_WINDOW_PEAK_EN
        chk("peak_out", row, int'(peak_out), ep);
`else
        if (ep < 0) n_cmp = n_cmp + 0;
`endif
    endtask

    task automatic step(input logic e, input logic v, input int p, input int t, input logic r);
        en      = e;
        pwr_vld = v;
        pwr_in  = IN_W'(p);
        thr     = IN_W'(t);
        avg_rdy = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Average: 4,8,12,16 -> 10
        add(1,0, 0,20,1,  0,0,0,0, 0);
        add(1,1, 4,20,1,  0,0,0,0, 0);
        add(1,1, 8,20,1,  0,0,0,0, 0);
        add(1,1,12,20,1,  0,0,0,0, 0);
        add(1,1,16,20,1, 10,1,0,0,16);
        add(1,0, 0,20,1, 10,0,0,0,16);
        // Gaps: 3,3,3,4 with idle cycles -> 3
        add(1,1, 3,20,1, 10,0,0,0,16);
        add(1,0, 0,20,1, 10,0,0,0,16);
        add(1,1, 3,20,1, 10,0,0,0,16);
        add(1,0, 0,20,1, 10,0,0,0,16);
        add(1,1, 3,20,1, 10,0,0,0,16);
        add(1,0, 0,20,1, 10,0,0,0,16);
        add(1,1, 4,20,1,  3,1,0,0, 4);
        add(1,0, 0,20,1,  3,0,0,0, 4);
        // Backpressure: avg 10 then 20 with avg_rdy=0
        add(1,1,10,30,0,  3,0,0,0, 4);
        add(1,1,10,30,0,  3,0,0,0, 4);
        add(1,1,10,30,0,  3,0,0,0, 4);
        add(1,1,10,30,0, 10,1,0,0,10);
        add(1,1,20,30,0, 10,1,0,0,10);
        add(1,1,20,30,0, 10,1,0,0,10);
        add(1,1,20,30,0, 10,1,0,0,10);
        add(1,1,20,30,0, 20,1,1,0,20);
        add(1,0, 0,30,0, 20,1,0,0,20);
        add(1,0, 0,30,1, 20,0,0,0,20);
        // Hysteresis: thr=20, averages 20,18,15
        add(1,1,20,20,1, 20,0,0,0,20);
        add(1,1,20,20,1, 20,0,0,0,20);
        add(1,1,20,20,1, 20,0,0,0,20);
        add(1,1,20,20,1, 20,1,0,1,20);
        add(1,1,18,20,1, 20,0,0,1,20);
        add(1,1,18,20,1, 20,0,0,1,20);
        add(1,1,18,20,1, 20,0,0,1,20);
        add(1,1,18,20,1, 18,1,0,1,18);
        add(1,1,15,20,1, 18,0,0,1,18);
        add(1,1,15,20,1, 18,0,0,1,18);
        add(1,1,15,20,1, 18,0,0,1,18);
        add(1,1,15,20,1, 15,1,0,0,15);
        add(1,0, 0,20,1, 15,0,0,0,15);
        // Accept coinciding with a new window end: no ovf
        add(1,1, 8,20,0, 15,0,0,0,15);
        add(1,1, 8,20,0, 15,0,0,0,15);
        add(1,1, 8,20,0, 15,0,0,0,15);
        add(1,1, 8,20,0,  8,1,0,0, 8);
        add(1,1,12,20,0,  8,1,0,0, 8);
        add(1,1,12,20,0,  8,1,0,0, 8);
        add(1,1,12,20,0,  8,1,0,0, 8);
        add(1,1,12,20,1, 12,1,0,0,12);
        add(1,0, 0,20,1, 12,0,0,0,12);
        // Abort: two samples, en drops (with a sample), then a full window of 8
        add(1,1, 8,20,1, 12,0,0,0,12);
        add(1,1, 8,20,1, 12,0,0,0,12);
        add(0,1, 8,20,1, 12,0,0,0,12);
        add(1,0, 0,20,1, 12,0,0,0,12);
        add(1,1, 8,20,1, 12,0,0,0,12);
        add(1,1, 8,20,1, 12,0,0,0,12);
        add(1,1, 8,20,1, 12,0,0,0,12);
        add(1,1, 8,20,1,  8,1,0,0, 8);
        add(1,0, 0,20,1,  8,0,0,0, 8);
        // Peak window: 5,40,7,1 -> avg 13, peak 40
        add(1,1, 5,20,1,  8,0,0,0, 8);
        add(1,1,40,20,1,  8,0,0,0, 8);
        add(1,1, 7,20,1,  8,0,0,0, 8);
        add(1,1, 1,20,1, 13,1,0,0,40);
        add(1,0, 0,20,1, 13,0,0,0,40);

        rst_n   = 1'b0;
        en      = 1'b0;
        pwr_vld = 1'b0;
        pwr_in  = '0;
        thr     = '0;
        avg_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all(-1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].vld, int'(vecs[i].p), int'(vecs[i].thr), vecs[i].rdy);
            chk_all(i, int'(vecs[i].eavg), vecs[i].evld, vecs[i].eovf,
                    vecs[i].ealm, int'(vecs[i].epk));
        end

        // Reset mid-window with a pending result and the alarm set.
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 16, 10, 0);
        end
        chk_all(100, 16, 1, 0, 1, 16);
        step(1, 1, 16, 10, 0);
        step(1, 1, 16, 10, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(101, 0, 0, 0, 0, 0);
        step(0, 0, 0, 10, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 16, 10, 1);
        chk_all(102, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
